// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an instruction and a data requester,
// with a one-cycle turnaround between transactions and an optional ready watchdog.
module mem_arbiter #(
    parameter int TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, IGNT, DGNT, TURN} state_t;

    // Wait count seen in the cycle that must expire: the counter starts at 0 in the first granted cycle.
    localparam logic [15:0] LP_LAST = 16'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t      r_state;
    logic        r_last_d;
    logic [15:0] r_wait;
    logic        r_mem_valid;
    logic        r_mem_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic w_ignt;
    logic w_dgnt;
    logic w_expire;
    logic w_done;
    logic w_pick_d;

    assign w_ignt   = r_state == IGNT;
    assign w_dgnt   = r_state == DGNT;
    assign w_expire = (TIMEOUT > 0) && (w_ignt || w_dgnt) && !memory_ready && (r_wait == LP_LAST);
    assign w_done   = (w_ignt || w_dgnt) && (memory_ready || w_expire);
    // On a tie the side that did not win last time gets the grant.
    assign w_pick_d = dmem_valid && (!imem_valid || !r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_wait      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imem_valid || dmem_valid) begin
                        r_state     <= w_pick_d ? DGNT : IGNT;
                        r_wait      <= '0;
                        r_mem_valid <= 1'b1;
                        r_mem_instr <= w_pick_d ? dmem_instr : imem_instr;
                        r_mem_addr  <= w_pick_d ? dmem_addr  : imem_addr;
                        r_mem_wdata <= w_pick_d ? dmem_wdata : imem_wdata;
                        r_mem_wstrb <= w_pick_d ? dmem_wstrb : imem_wstrb;
                    end
                end
                IGNT, DGNT: begin
                    if (w_done) begin
                        r_state     <= TURN;
                        r_mem_valid <= 1'b0;
                        r_last_d    <= w_dgnt;
                    end else if (TIMEOUT > 0) begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign memory_valid = r_mem_valid;
    assign memory_instr = r_mem_instr;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;

    // A watchdog completion returns zero data; a real ready forwards the memory data.
    assign imem_ready  = w_done && w_ignt;
    assign dmem_ready  = w_done && w_dgnt;
    assign imem_rdata  = (w_ignt && memory_ready) ? memory_rdata : '0;
    assign dmem_rdata  = (w_dgnt && memory_ready) ? memory_rdata : '0;
    assign timeout_err = w_expire;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against mem_arbiter (TIMEOUT=8); a transaction-level
// arbitration model queues expected grants, and an independent monitor checks every DUT response.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_valid = 1'b0, imem_instr = 1'b0;
    logic [31:0] imem_addr = '0, imem_wdata = '0;
    logic [3:0]  imem_wstrb = '0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0, dmem_instr = 1'b0;
    logic [31:0] dmem_addr = '0, dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        memory_valid, memory_instr;
    logic [31:0] memory_addr, memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata = '0;
    logic        memory_ready = 1'b0;
    logic        timeout_err;

    int compared = 0;
    int mismatched = 0;
    bit mem_en = 1'b1;
    bit noise = 1'b0;
    int fixed_lat = -1;

    typedef struct {
        bit          d;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gap;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit d, input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
        if (d) begin
            dmem_valid = v; dmem_instr = ins; dmem_addr = a; dmem_wdata = w; dmem_wstrb = s;
        end else begin
            imem_valid = v; imem_instr = ins; imem_addr = a; imem_wdata = w; imem_wstrb = s;
        end
    endtask

    task automatic drop(input bit d);
        if (d) dmem_valid = 1'b0;
        else imem_valid = 1'b0;
    endtask

    task automatic wait_ready(input bit d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d ? dmem_ready : imem_ready) && n < 200);
        if (d) chk("dmem_handshake", 64'(n < 200), 64'(1));
        else chk("imem_handshake", 64'(n < 200), 64'(1));
    endtask

    task automatic run_side(input bit d, input int n);
        for (int i = 0; i < n; i++) begin
            int idle;
            idle = (i == 0 || $urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 4));
            repeat (idle) begin
                @(posedge clk);
                #1;
            end
            drive(d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            wait_ready(d);
            @(posedge clk);
            #1;
            drop(d);
        end
    endtask

    task automatic req(input bit d, input logic ins, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input int lat, input bit en);
        @(negedge clk);
        fixed_lat = lat;
        mem_en = en;
        @(posedge clk);
        #1;
        drive(d, 1'b1, ins, a, w, s);
        wait_ready(d);
        @(posedge clk);
        #1;
        drop(d);
    endtask

    // Memory responder: ready after a random (or forced) number of valid cycles; random noise elsewhere.
    initial begin
        int cnt, lat;
        cnt = 0;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (memory_valid) begin
                if (cnt == 0) lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 5));
                memory_ready = mem_en && cnt == lat;
                cnt++;
            end else begin
                cnt = 0;
                memory_ready = noise && ($urandom_range(0, 1) == 1);
            end
            memory_rdata = $urandom;
        end
    end

    // Reference model: who gets the memory next, and how long the bus was idle before it.
    initial begin
        int ph, wt;
        bit last_d, first, fresh, side, pick_d;
        exp_t e;
        ph = 0; wt = 0; last_d = 0; first = 1; fresh = 0; side = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                q.delete();
                ph = 0; wt = 0; last_d = 0; first = 1; fresh = 0;
            end else if (ph == 0) begin
                if (imem_valid || dmem_valid) begin
                    pick_d  = (imem_valid && dmem_valid) ? !last_d : dmem_valid;
                    e.d     = pick_d;
                    e.instr = pick_d ? dmem_instr : imem_instr;
                    e.addr  = pick_d ? dmem_addr : imem_addr;
                    e.wdata = pick_d ? dmem_wdata : imem_wdata;
                    e.wstrb = pick_d ? dmem_wstrb : imem_wstrb;
                    e.gap   = first ? 0 : (fresh ? 2 : 3);
                    q.push_back(e);
                    side = pick_d; ph = 1; wt = 0; first = 0;
                end
                fresh = 0;
            end else if (ph == 1) begin
                wt++;
                if (memory_ready || wt == TO) begin
                    ph = 2;
                    last_d = side;
                end
            end else begin
                ph = 0;
                fresh = 1;
            end
        end
    end

    // Monitor: pops an expected grant when memory_valid rises and checks every cycle of it.
    initial begin
        exp_t cur;
        bit act, jf, to, fin;
        int cnt, low;
        act = 0; jf = 0; cnt = 0; low = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_mem", 64'({memory_valid, memory_instr, memory_wstrb}), 64'(0));
                chk("reset_rsp", 64'({imem_ready, dmem_ready, timeout_err}), 64'(0));
                chk("reset_rdata", {imem_rdata, dmem_rdata}, 64'(0));
                act = 0; jf = 0; low = 0;
            end else begin
                if (jf) chk("valid_drop", 64'(memory_valid), 64'(0));
                jf = 0;
                if (!act && memory_valid) begin
                    chk("grant_pending", 64'(q.size() > 0), 64'(1));
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        chk("grant_instr", 64'(memory_instr), 64'(cur.instr));
                        chk("grant_addr", 64'(memory_addr), 64'(cur.addr));
                        chk("grant_wdata", 64'(memory_wdata), 64'(cur.wdata));
                        chk("grant_wstrb", 64'(memory_wstrb), 64'(cur.wstrb));
                        if (cur.gap == 2) chk("gap_exact", 64'(low), 64'(2));
                        else if (cur.gap == 3) chk("gap_min", 64'(low >= 3), 64'(1));
                        act = 1;
                        cnt = 0;
                    end
                end
                if (act) begin
                    cnt++;
                    chk("mem_valid_held", 64'(memory_valid), 64'(1));
                    chk("payload_held", {memory_wdata, memory_addr}, {cur.wdata, cur.addr});
                    to  = cnt == TO && !memory_ready;
                    fin = memory_ready || to;
                    chk("imem_ready", 64'(imem_ready), 64'(fin && !cur.d));
                    chk("dmem_ready", 64'(dmem_ready), 64'(fin && cur.d));
                    chk("imem_rdata", 64'(imem_rdata), 64'((!cur.d && memory_ready) ? memory_rdata : 32'h0));
                    chk("dmem_rdata", 64'(dmem_rdata), 64'((cur.d && memory_ready) ? memory_rdata : 32'h0));
                    chk("timeout_err", 64'(timeout_err), 64'(to));
                    if (fin) begin
                        act = 0;
                        jf = 1;
                    end
                end else begin
                    chk("idle_rsp", 64'({imem_ready, dmem_ready, timeout_err}), 64'(0));
                    chk("idle_rdata", {imem_rdata, dmem_rdata}, 64'(0));
                end
                low = memory_valid ? 0 : low + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", compared, mismatched);
        $fatal(1);
    end

    initial begin
        int n;
        noise = 1'b1;
        mem_en = 1'b1;
        fixed_lat = -1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        // Both sides start together: the data side must win the first tie, then strict alternation.
        fork
            run_side(1'b0, 30);
            run_side(1'b1, 30);
        join
        req(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 2, 1'b1);
        req(1'b0, 1'b1, 32'h2000, 32'h0, 4'h0, 0, 1'b1);
        req(1'b1, 1'b0, 32'h104, 32'hCAFEF00D, 4'h3, TO - 1, 1'b1);
        req(1'b1, 1'b0, 32'h108, 32'h1, 4'h1, 0, 1'b0);
        // Reset in the middle of a data grant, with an instruction request pending across release.
        @(negedge clk);
        mem_en = 1'b0;
        fixed_lat = -1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h55AA55AA, 4'hC);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memory_valid && n < 20);
        chk("dgnt_seen", 64'(memory_valid), 64'(1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_mem", 64'({memory_valid, memory_instr, memory_wstrb}), 64'(0));
        chk("async_payload", {memory_addr, memory_wdata}, 64'(0));
        chk("async_rsp", 64'({imem_ready, dmem_ready, timeout_err}), 64'(0));
        chk("async_rdata", {imem_rdata, dmem_rdata}, 64'(0));
        drop(1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 4'h0);
        mem_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        drop(1'b0);
        repeat (6) @(negedge clk);
        chk("drain", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT, default 0, SHALL set the maximum memory_ready wait in cycles; 0 disables the watchdog; range 0..65535.
REQ-003 Port rst  in  1  SHALL be the asynchronous reset, active-low.
REQ-004 Port clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 Ports imem_valid/imem_instr  in  1 each  SHALL carry the instruction-side request flag and instr tag.
REQ-006 Ports imem_addr/imem_wdata  in  32 each, and imem_wstrb  in  4, SHALL carry the instruction-side request payload.
REQ-007 Ports imem_rdata  out  32 and imem_ready  out  1 SHALL carry the instruction-side response.
REQ-008 Ports dmem_valid/dmem_instr/dmem_addr/dmem_wdata/dmem_wstrb/dmem_rdata/dmem_ready SHALL mirror REQ-005..007 for the data side.
REQ-009 Ports memory_valid/memory_instr  out  1, memory_addr/memory_wdata  out  32 and memory_wstrb  out  4 SHALL drive the shared downstream request.
REQ-010 Ports memory_rdata  in  32 and memory_ready  in  1 SHALL carry the downstream response.
REQ-011 Port timeout_err  out  1 SHALL be a one-cycle watchdog error pulse.

Function
REQ-012 FSM states SHALL be IDLE, IGNT, DGNT and TURN; a last_d flag SHALL record the most recent grant.
REQ-013 In IDLE, with exactly one requester valid, that side SHALL be granted; with both valid, the side not equal to last_d SHALL be granted (round-robin); with none valid, the FSM SHALL stay in IDLE.
REQ-014 On the grant edge, instr/addr/wdata/wstrb of the granted side SHALL be registered onto the memory_* outputs, and memory_valid SHALL be 1 from the next cycle (request seen in cycle N -> memory_valid in cycle N+1).
REQ-015 In IGNT/DGNT, the memory_* outputs SHALL stay stable until memory_ready=1.
REQ-016 In a cycle with memory_ready=1 in xGNT, x_ready SHALL be 1 combinationally in the same cycle and x_rdata SHALL equal memory_rdata.
REQ-017 After the REQ-016 cycle, the FSM SHALL go to TURN, memory_valid SHALL be 0, and last_d SHALL be updated.
REQ-018 The non-granted side's ready SHALL be 0 and its rdata SHALL be 0 at all times; both sides' ready and rdata SHALL be 0 in IDLE and TURN.
REQ-019 TURN SHALL last exactly one cycle with no grant, then the FSM SHALL go to IDLE; the downstream gap between transactions is therefore 2 cycles.
REQ-020 memory_ready asserted in IDLE or TURN SHALL be ignored.
REQ-021 A requester dropping valid while granted (protocol violation) SHALL not abort the transaction; completion proceeds per REQ-016.
REQ-022 With TIMEOUT>0, a 16-bit wait counter SHALL clear on grant and increment each xGNT cycle without memory_ready.
REQ-023 With TIMEOUT>0, on the TIMEOUT-th consecutive memory_valid cycle without ready: timeout_err=1, x_ready=1 and x_rdata=0 for one cycle, then the FSM goes to TURN.
REQ-024 memory_ready coincident with the timeout cycle SHALL win: normal completion, timeout_err=0.

Reset
REQ-025 Asserting rst=0 SHALL immediately force state IDLE, last_d=0, wait counter 0, and all outputs to 0 (memory_*, imem/dmem ready and rdata, timeout_err).
REQ-026 Reset mid-transaction SHALL abandon that transaction silently; requests after release SHALL be granted per REQ-013, with the data side winning a tie.

Verification
REQ-027 dmem only, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF, memory_ready 2 cycles after memory_valid -> memory_valid at N+1 with matching payload; dmem_ready 1-cycle pulse coincident with memory_ready; imem_ready stays 0.
REQ-028 Both sides valid after reset -> D granted first, then I; a third tie -> D (strict alternation); rdata routed only to the granted side.
REQ-029 Continuous imem requests with memory_ready 1 cycle after valid -> memory_valid low exactly 2 cycles between transactions.
REQ-030 TIMEOUT=8, dmem request, memory_ready held 0 -> on 8th memory_valid cycle timeout_err=1, dmem_ready=1, dmem_rdata=0; memory_valid=0 next cycle.
REQ-031 rst=0 mid-DGNT -> all outputs 0 with no clock edge; after release a pending imem request is granted per REQ-014.
REQ-032 memory_ready=1 with rdata 0x12345678 while in IDLE/TURN -> imem_ready=dmem_ready=0 and both rdata=0.
